// File: rtl/maxpool2d.sv
// Max-pooling stage with optional ReLU: scans one window element per cycle with a single
// signed 32-bit comparator and writes each pooled pixel on its window's last element.
module maxpool2d #(
    parameter int pool_size    = 2,
    parameter int stride       = 2,
    parameter int input_width  = 4,
    parameter int output_width = 2,
    parameter bit relu_en      = 1'b1
) (
    input  logic                                               clk,
    input  logic                                               reset,
    input  logic                                               start,
    input  logic signed [input_width*input_width*32-1:0]       input_image,
    output logic signed [output_width*output_width*32-1:0]     output_image,
    output logic                                               busy,
    output logic                                               done
);

    localparam int PW  = (pool_size > 1) ? $clog2(pool_size) : 1;
    localparam int OWW = (output_width > 1) ? $clog2(output_width) : 1;
    localparam int OUT_BITS = output_width * output_width * 32;
    localparam int unsigned STR = stride;
    localparam int unsigned IW  = input_width;
    localparam int unsigned OW  = output_width;
    localparam logic [PW-1:0]  P_LAST = PW'(pool_size - 1);
    localparam logic [OWW-1:0] O_LAST = OWW'(output_width - 1);

    generate
        if (pool_size < 1 || stride < 1 ||
            output_width != (input_width - pool_size) / stride + 1) begin : g_param_check
            $error("maxpool2d: output_width inconsistent with input_width/pool_size/stride");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t                 state_q, state_d;
    logic [PW-1:0]          wx_q, wx_d, wy_q, wy_d;
    logic [OWW-1:0]         ox_q, ox_d, oy_q, oy_d;
    logic signed [31:0]     max_q, max_d;
    logic [OUT_BITS-1:0]    out_q, out_d;

    logic signed [31:0]     pix, cand, final_val;
    logic                   first_el, last_el, last_out;
    int unsigned            row, col, pidx, oidx;

    always_comb begin
        row  = int'(oy_q) * STR + int'(wy_q);
        col  = int'(ox_q) * STR + int'(wx_q);
        pidx = row * IW + col;
        oidx = int'(oy_q) * OW + int'(ox_q);
        pix  = input_image[pidx*32 +: 32];
        first_el = (wx_q == '0) && (wy_q == '0);
        last_el  = (wx_q == P_LAST) && (wy_q == P_LAST);
        last_out = last_el && (ox_q == O_LAST) && (oy_q == O_LAST);
        // First element seeds the max; later elements win only when strictly greater.
        cand = (first_el || (pix > max_q)) ? pix : max_q;
        final_val = (relu_en && cand < 0) ? 32'sd0 : cand;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = SCAN;
            SCAN:    if (last_out) state_d = DONE;
            DONE:    if (start) state_d = SCAN;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q == SCAN);
        done = (state_q == DONE);
    end

    always_comb begin
        wx_d  = wx_q;
        wy_d  = wy_q;
        ox_d  = ox_q;
        oy_d  = oy_q;
        max_d = max_q;
        out_d = out_q;
        if (state_q != SCAN) begin
            if (start) begin
                wx_d = '0;
                wy_d = '0;
                ox_d = '0;
                oy_d = '0;
            end
        end else begin
            max_d = cand;
            if (last_el) out_d[oidx*32 +: 32] = final_val;
            if (wx_q == P_LAST) begin
                wx_d = '0;
                if (wy_q == P_LAST) begin
                    wy_d = '0;
                    if (ox_q == O_LAST) begin
                        ox_d = '0;
                        oy_d = (oy_q == O_LAST) ? '0 : oy_q + 1'b1;
                    end else begin
                        ox_d = ox_q + 1'b1;
                    end
                end else begin
                    wy_d = wy_q + 1'b1;
                end
            end else begin
                wx_d = wx_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wx_q  <= '0;
            wy_q  <= '0;
            ox_q  <= '0;
            oy_q  <= '0;
            max_q <= '0;
            out_q <= '0;
        end else begin
            wx_q  <= wx_d;
            wy_q  <= wy_d;
            ox_q  <= ox_d;
            oy_q  <= oy_d;
            max_q <= max_d;
            out_q <= out_d;
        end
    end

    assign output_image = out_q;

endmodule

// File: tb/tb_maxpool2d.sv
// Self-checking bench for maxpool2d: three configurations checked against a pooling model
// every cycle, plus hand-computed literal expectations.
module tb_maxpool2d;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic start_a = 1'b0;
    logic start_c = 1'b0;

    int img_a[16];
    int img_c[25];
    logic [511:0] bus_a;
    logic [799:0] bus_c;
    logic [127:0] out_a, out_b;
    logic [287:0] out_c;
    logic busy_a, done_a, busy_b, done_b, busy_c, done_c;

    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < 16; i++) bus_a[i*32 +: 32] = img_a[i];
    end
    always_comb begin
        for (int i = 0; i < 25; i++) bus_c[i*32 +: 32] = img_c[i];
    end

    maxpool2d #(.pool_size(2), .stride(2), .input_width(4), .output_width(2), .relu_en(1'b1)) dut_a (
        .clk(clk), .reset(reset), .start(start_a), .input_image(bus_a),
        .output_image(out_a), .busy(busy_a), .done(done_a));

    maxpool2d #(.pool_size(2), .stride(2), .input_width(4), .output_width(2), .relu_en(1'b0)) dut_b (
        .clk(clk), .reset(reset), .start(start_a), .input_image(bus_a),
        .output_image(out_b), .busy(busy_b), .done(done_b));

    maxpool2d #(.pool_size(3), .stride(1), .input_width(5), .output_width(3), .relu_en(1'b1)) dut_c (
        .clk(clk), .reset(reset), .start(start_c), .input_image(bus_c),
        .output_image(out_c), .busy(busy_c), .done(done_c));

    // Pooled value of one output pixel, straight from the window definition.
    function automatic int pool_px(input int img[25], input int p, input int s, input int iw,
                                   input bit relu, input int oy, input int ox);
        int m;
        int v;
        m = img[(oy*s)*iw + ox*s];
        for (int wy = 0; wy < p; wy++)
            for (int wx = 0; wx < p; wx++) begin
                v = img[(oy*s+wy)*iw + ox*s + wx];
                if (v > m) m = v;
            end
        if (relu && m < 0) m = 0;
        return m;
    endfunction

    int img_a25[25];
    int res_a[4], res_b[4], res_c[9];
    always_comb begin
        for (int i = 0; i < 25; i++) img_a25[i] = (i < 16) ? img_a[i] : 0;
    end
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            res_a[i] = pool_px(img_a25, 2, 2, 4, 1'b1, i / 2, i % 2);
            res_b[i] = pool_px(img_a25, 2, 2, 4, 1'b0, i / 2, i % 2);
        end
    end
    always_comb begin
        for (int i = 0; i < 9; i++) res_c[i] = pool_px(img_c, 3, 1, 5, 1'b1, i / 3, i % 3);
    end

    // Run-level model: a run lasts NRUN edges after the accepting edge, then holds done.
    int nrun[3] = '{16, 16, 81};
    int mcnt[3] = '{0, 0, 0};
    bit mbusy[3] = '{0, 0, 0};
    bit mdone[3] = '{0, 0, 0};
    int exp_a[4] = '{default: 0};
    int exp_b[4] = '{default: 0};
    int exp_c[9] = '{default: 0};

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            mcnt  <= '{0, 0, 0};
            mbusy <= '{0, 0, 0};
            mdone <= '{0, 0, 0};
            exp_a <= '{default: 0};
            exp_b <= '{default: 0};
            exp_c <= '{default: 0};
        end else begin
            for (int k = 0; k < 3; k++) begin
                if (mbusy[k]) begin
                    mcnt[k] <= mcnt[k] + 1;
                    if (mcnt[k] + 1 == nrun[k]) begin
                        mbusy[k] <= 1'b0;
                        mdone[k] <= 1'b1;
                        if (k == 0) exp_a <= res_a;
                        if (k == 1) exp_b <= res_b;
                        if (k == 2) exp_c <= res_c;
                    end
                end else if ((k == 2) ? start_c : start_a) begin
                    mbusy[k] <= 1'b1;
                    mdone[k] <= 1'b0;
                    mcnt[k]  <= 0;
                end
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    function automatic int px(input logic [287:0] v, input int i);
        return $signed(v[i*32 +: 32]);
    endfunction

    always @(negedge clk) begin
        check("busy_a", int'(busy_a), int'(mbusy[0]));
        check("done_a", int'(done_a), int'(mdone[0]));
        check("busy_b", int'(busy_b), int'(mbusy[1]));
        check("done_b", int'(done_b), int'(mdone[1]));
        check("busy_c", int'(busy_c), int'(mbusy[2]));
        check("done_c", int'(done_c), int'(mdone[2]));
        if (!mbusy[0])
            for (int i = 0; i < 4; i++) check($sformatf("out_a[%0d]", i), px(288'(out_a), i), exp_a[i]);
        if (!mbusy[1])
            for (int i = 0; i < 4; i++) check($sformatf("out_b[%0d]", i), px(288'(out_b), i), exp_b[i]);
        if (!mbusy[2])
            for (int i = 0; i < 9; i++) check($sformatf("out_c[%0d]", i), px(out_c, i), exp_c[i]);
    end

    // Pulse start, then count edges until done; optional second start and mid-run reset.
    task automatic go(input bit usec, input int restart_at, input int abort_at, output int edges);
        @(negedge clk);
        if (usec) start_c = 1'b1; else start_a = 1'b1;
        @(posedge clk); #1;
        check("start_busy", int'(usec ? busy_c : busy_a), 1);
        check("start_done_clear", int'(usec ? done_c : done_a), 0);
        @(negedge clk);
        start_a = 1'b0;
        start_c = 1'b0;
        edges = -1;
        for (int e = 1; e <= 200; e++) begin
            @(posedge clk); #1;
            if (e == restart_at) begin
                if (usec) start_c = 1'b1; else start_a = 1'b1;
            end
            if (e == restart_at + 1) begin
                start_a = 1'b0;
                start_c = 1'b0;
            end
            if (e == abort_at) begin
                #1 reset = 1'b1;
                #1;
                check("async_rst_busy_a", int'(busy_a), 0);
                check("async_rst_done_b", int'(done_b), 0);
                check("async_rst_out_a", int'(out_a != '0), 0);
                check("async_rst_out_b", int'(out_b != '0), 0);
                @(negedge clk);
                reset = 1'b0;
                return;
            end
            if (usec ? done_c : done_a) begin
                edges = e;
                break;
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int e;
        for (int i = 0; i < 16; i++) img_a[i] = 0;
        for (int i = 0; i < 25; i++) img_c[i] = 0;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        check("reset_out_a", int'(out_a != '0), 0);
        check("reset_busy_a", int'(busy_a), 0);

        for (int i = 0; i < 16; i++) img_a[i] = i;
        go(1'b0, 0, 0, e);
        check("latency_ramp", e, 16);
        check("ramp_a0", px(288'(out_a), 0), 5);
        check("ramp_a1", px(288'(out_a), 1), 7);
        check("ramp_a2", px(288'(out_a), 2), 13);
        check("ramp_a3", px(288'(out_a), 3), 15);

        for (int i = 0; i < 16; i++) img_a[i] = -3;
        img_a[15] = -1;
        go(1'b0, 3, 0, e);
        check("latency_restart_ignored", e, 16);
        for (int i = 0; i < 4; i++) check($sformatf("relu_a%0d", i), px(288'(out_a), i), 0);
        check("norelu_b0", px(288'(out_b), 0), -3);
        check("norelu_b2", px(288'(out_b), 2), -3);
        check("norelu_b3", px(288'(out_b), 3), -1);

        for (int i = 0; i < 16; i++) img_a[i] = 0;
        img_a[0] = int'(32'h8000_0000);
        img_a[1] = 2147483647;
        img_a[4] = -1;
        img_a[5] = 0;
        go(1'b0, 0, 0, e);
        check("latency_from_done", e, 16);
        check("signed_a0", px(288'(out_a), 0), 2147483647);
        check("signed_b0", px(288'(out_b), 0), 2147483647);

        for (int i = 0; i < 16; i++) img_a[i] = 0;
        img_a[0] = 9; img_a[1] = 9; img_a[4] = 9; img_a[5] = 9;
        go(1'b0, 0, 0, e);
        check("tie_a0", px(288'(out_a), 0), 9);

        for (int i = 0; i < 16; i++) img_a[i] = i;
        go(1'b0, 0, 6, e);
        go(1'b0, 0, 0, e);
        check("latency_after_reset", e, 16);
        check("post_rst_a0", px(288'(out_a), 0), 5);
        check("post_rst_a3", px(288'(out_a), 3), 15);

        for (int y = 0; y < 5; y++)
            for (int x = 0; x < 5; x++) img_c[y*5+x] = y*5 + x;
        go(1'b1, 0, 0, e);
        check("latency_p3", e, 81);
        check("p3_c0", px(out_c, 0), 12);
        check("p3_c4", px(out_c, 4), 18);
        check("p3_c8", px(out_c, 8), 24);

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
